baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//  Programmable baud-rate generator with a fractional divider and oversample ticks, for UART TX/RX.
//  Produces an oversample tick (o_os_tick), a mid-bit tick (o_mid_tick) for RX sampling and
//    a bit tick (o_bit_tick) for TX shifting.
//  The divisor is runtime-loadable and takes effect only on a bit boundary.
//  i_resync realigns the bit phase to an RX start-bit edge.
// PARAMETERS
//  CLK_FREQ    100000000  system clock in Hz
//  DEF_BAUD    115200     baud rate used after reset
//  OVERSAMPLE  16         os ticks per bit; even, >=4
//  DIV_W       16         width of the integer divisor
//  FRAC_W      4          width of the fractional divisor (units of 1/2^FRAC_W)
//  Reset divisor: D = (CLK_FREQ*2^FRAC_W)/(DEF_BAUD*OVERSAMPLE), floor.
//    Integer part = D>>FRAC_W, fraction = D mod 2^FRAC_W. Defaults give 54 + 4/16.
// PORTS
//  i_clk        in   1       system clock, rising edge
//  i_rst_n      in   1       asynchronous reset, active low
//  i_en         in   1       1 = generate ticks; 0 = clear and hold the phase
//  i_div_int    in   DIV_W   integer clocks per os tick
//  i_div_frac   in   FRAC_W  fractional clocks per os tick
//  i_div_load   in   1       1-cycle strobe: capture i_div_int/i_div_frac into the pending register
//  i_resync     in   1       1-cycle strobe: restart the bit phase from zero
//  o_os_tick    out  1       1-cycle pulse once per oversample period
//  o_mid_tick   out  1       1-cycle pulse at os index OVERSAMPLE/2-1 (bit centre)
//  o_bit_tick   out  1       1-cycle pulse at os index OVERSAMPLE-1 (bit end)
//  o_load_pend  out  1       1 while a loaded divisor is waiting for a bit boundary
// BEHAVIOUR
//  Reset: active divisor = defaults; pending register cleared.
//    cnt, acc and os_idx are 0. All outputs are 0.
//  Period: active int I is clamped to a minimum of 2, then P = I + carry, where carry comes from the
//    FRAC_W-bit accumulator. On each os tick, acc <= acc + F; carry = overflow of that sum.
//    The carry lengthens the next period by 1.
//  cnt counts 0..P-1. When cnt==P-1, cnt <= 0 and the os tick is issued.
//    All ticks are registered and appear on the following cycle.
//  First o_os_tick: I clocks after the first cycle in which i_en is sampled 1.
//  Long-run bit period = OVERSAMPLE*I + (OVERSAMPLE*F)/2^FRAC_W clocks; exact when that is an integer.
//  os_idx counts 0..OVERSAMPLE-1 on each os tick and wraps to 0.
//    o_mid_tick / o_bit_tick pulse in the same cycle as the o_os_tick that ends os_idx
//    OVERSAMPLE/2-1 / OVERSAMPLE-1.
//  Divisor load:
//    - i_div_load writes the pending register and sets o_load_pend; a second load overwrites it.
//    - The pending value becomes active in the cycle o_bit_tick is asserted; acc is cleared then.
//      The next period uses the new value and o_load_pend clears.
//    - If i_en==0, the load takes effect on the next cycle.
//  i_resync: next cycle cnt, acc, os_idx = 0; no tick is issued that cycle.
//    Resync has priority over a coincident tick. A pending load stays pending.
//  i_en==0: cnt, acc, os_idx held at 0; outputs 0 from the next cycle.
//  Reset asserted mid-operation: everything returns to the reset state immediately, including
//    the pending register and o_load_pend.
//  No combinational path from any input to any output.
// TESTING
//  1. Reset defaults, en=1: o_bit_tick spacing 868 clk; os spacing 54,54,54,55 repeating.
//  2. load I=4 F=0: os every 4 clk, mid at 32nd clk of bit, bit tick every 64 clk.
//  3. load I=4 F=8: os periods 4,5 alternating; bit tick every 72 clk.
//  4. load I=0 and I=1: both clamp to period 2; bit tick every 32 clk.
//  5. load I=8 mid-bit: o_load_pend=1 until bit tick; the old rate holds until the boundary,
//     the new rate applies after it.
//  6. resync on a cycle where cnt==P-1: no tick issued; the next os tick comes P clk later.
//     Reset pulse mid-bit: outputs 0 and defaults restored.

Source files
------------

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: programmable fractional baud-rate generator.
// Emits an oversample tick, a mid-bit tick and a bit-end tick. Divisor changes
// are staged in a pending register and committed only on a bit boundary.
module baud_gen_frac #(
  parameter int CLK_FREQ   = 100000000,
  parameter int DEF_BAUD   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_mid_tick,
  output logic              o_bit_tick,
  output logic              o_load_pend
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  // Reset divisor in units of 1/2^FRAC_W clock, floored.
  localparam longint unsigned DEF_D =
    (longint'(CLK_FREQ) << FRAC_W) / (longint'(DEF_BAUD) * longint'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_D >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_D);

  localparam logic [OS_W-1:0] MID_IDX  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] LAST_IDX = OS_W'(OVERSAMPLE - 1);

  // Active and pending divisor
  logic [DIV_W-1:0]  act_int_r;
  logic [FRAC_W-1:0] act_frac_r;
  logic [DIV_W-1:0]  pend_int_r;
  logic [FRAC_W-1:0] pend_frac_r;
  logic              pend_r;

  // Phase state
  logic [DIV_W-1:0]  cnt_r;
  logic [FRAC_W-1:0] acc_r;
  logic              carry_r;
  logic [OS_W-1:0]   os_idx_r;

  // Registered ticks
  logic              os_tick_r;
  logic              mid_tick_r;
  logic              bit_tick_r;

  // Combinational helpers
  logic [DIV_W:0]    int_eff_s;
  logic [DIV_W:0]    last_cnt_s;
  logic [FRAC_W:0]   acc_sum_s;
  logic              os_end_s;
  logic              mid_end_s;
  logic              bit_end_s;
  logic              apply_s;

  // Period end detection, accumulator sum and pending-divisor commit decision
  always_comb begin
    int_eff_s  = {1'b0, act_int_r};
    last_cnt_s = '0;
    acc_sum_s  = '0;
    os_end_s   = 1'b0;
    mid_end_s  = 1'b0;
    bit_end_s  = 1'b0;
    apply_s    = 1'b0;

    // Periods shorter than 2 clocks would make the tick pulses merge.
    if (act_int_r < DIV_W'(2)) begin
      int_eff_s = (DIV_W + 1)'(2);
    end else begin
      int_eff_s = {1'b0, act_int_r};
    end

    // A carry from the previous os tick stretches this period by one clock.
    last_cnt_s = int_eff_s + {{DIV_W{1'b0}}, carry_r} - {{DIV_W{1'b0}}, 1'b1};
    acc_sum_s  = {1'b0, acc_r} + {1'b0, act_frac_r};

    // Resync wins over a coincident period end, so no tick is issued then.
    os_end_s  = i_en && !i_resync && ({1'b0, cnt_r} == last_cnt_s);
    mid_end_s = os_end_s && (os_idx_r == MID_IDX);
    bit_end_s = os_end_s && (os_idx_r == LAST_IDX);

    // While disabled there is no phase to protect, so commit straight away.
    apply_s = pend_r && (!i_en || bit_end_s);
  end

  // Divisor staging: capture loads, commit them on a bit boundary or while idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_int_r   <= DEF_INT;
      act_frac_r  <= DEF_FRAC;
      pend_int_r  <= '0;
      pend_frac_r <= '0;
      pend_r      <= 1'b0;
    end else begin
      if (apply_s) begin
        act_int_r  <= pend_int_r;
        act_frac_r <= pend_frac_r;
      end else begin
        act_int_r  <= act_int_r;
        act_frac_r <= act_frac_r;
      end
      // A load in the commit cycle becomes the next pending value.
      if (i_div_load) begin
        pend_int_r  <= i_div_int;
        pend_frac_r <= i_div_frac;
        pend_r      <= 1'b1;
      end else if (apply_s) begin
        pend_r      <= 1'b0;
      end else begin
        pend_r      <= pend_r;
      end
    end
  end

  // Phase counters, fractional accumulator and registered tick generation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r      <= '0;
      acc_r      <= '0;
      carry_r    <= 1'b0;
      os_idx_r   <= '0;
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end else if (!i_en || i_resync) begin
      cnt_r      <= '0;
      acc_r      <= '0;
      carry_r    <= 1'b0;
      os_idx_r   <= '0;
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end else if (os_end_s) begin
      cnt_r      <= '0;
      os_tick_r  <= 1'b1;
      mid_tick_r <= mid_end_s;
      bit_tick_r <= bit_end_s;
      if (bit_end_s) begin
        os_idx_r <= '0;
      end else begin
        os_idx_r <= os_idx_r + OS_W'(1);
      end
      // A newly committed divisor starts with a clean fractional phase.
      if (apply_s) begin
        acc_r   <= '0;
        carry_r <= 1'b0;
      end else begin
        acc_r   <= acc_sum_s[FRAC_W-1:0];
        carry_r <= acc_sum_s[FRAC_W];
      end
    end else begin
      cnt_r      <= cnt_r + DIV_W'(1);
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end
  end

  assign o_os_tick   = os_tick_r;
  assign o_mid_tick  = mid_tick_r;
  assign o_bit_tick  = bit_tick_r;
  assign o_load_pend = pend_r;

endmodule
